// File: rtl/wb_io_arbiter_if.sv
// ============================================================================
//  Module      : wb_io_arbiter_if
//  Description : Wishbone bus bundle used on both sides of wb_io_arbiter.
//                N lanes of request signals are packed side by side, lane k
//                at [W*k+W-1:W*k]. The read data return path is shared by all
//                lanes. The per-lane ack/err/rty vectors are N bits wide.
//                The master modport drives requests. The slave modport
//                drives responses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_io_arbiter_if #(
    parameter int N = 1
) ();
    logic [32*N-1:0] adr;
    logic [32*N-1:0] dat_w;
    logic [4*N-1:0]  sel;
    logic [N-1:0]    we;
    logic [N-1:0]    cyc;
    logic [N-1:0]    stb;
    logic [3*N-1:0]  cti;
    logic [2*N-1:0]  bte;
    logic [31:0]     dat_r;
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [N-1:0]    rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

`default_nettype wire

// File: rtl/wb_io_arbiter.sv
// ============================================================================
//  Module      : wb_io_arbiter
//  Description : Round-robin arbiter that shares the single Wishbone IO port
//                of the SoC interconnect between NUM_MASTERS requesters.
//                * One master owns the bus for a whole Wishbone cycle. It
//                  keeps ownership until it drops cyc.
//                * Arbitration takes place only in IDLE. This guarantees at
//                  least one idle cycle between two owners.
//                * Only the owner receives ack, err and rty. Read data is
//                  broadcast to all masters.
//                Optional feature (macro WB_ARB_TIMEOUT_EN): a stall
//                watchdog aborts the owner's cycle with a one-cycle err
//                after TIMEOUT_CYCLES waiting cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_io_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                   wb_clk_i,
    input  wire logic                   wb_rst_n_i,
    wb_io_arbiter_if.slave              wbm,
    wb_io_arbiter_if.master             wbs,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int IDXW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    // last_q serves two purposes: it is the round-robin pointer and, while
    // in OWN, it is the index of the owner.
    logic [IDXW-1:0]        last_q,  last_d;

    logic                   is_own;
    logic                   own_cyc;
    logic                   own_stb;
    logic                   own_we;
    logic [31:0]            own_adr;
    logic [31:0]            own_dat;
    logic [3:0]             own_sel;
    logic [2:0]             own_cti;
    logic [1:0]             own_bte;

    logic                   req_found;
    logic [IDXW-1:0]        win_idx;
    int                     cand;

    logic                   slv_resp;
    logic                   timeout;

    assign is_own   = (state_q == ST_OWN);
    assign slv_resp = wbs.ack[0] | wbs.err[0] | wbs.rty[0];
    assign grant_o  = grant_q;

    // Select the request lane of the current pointer/owner.
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_cti = '0;
        own_bte = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (last_q == IDXW'(k)) begin
                own_cyc = wbm.cyc[k];
                own_stb = wbm.stb[k];
                own_we  = wbm.we[k];
                own_adr = wbm.adr[32*k +: 32];
                own_dat = wbm.dat_w[32*k +: 32];
                own_sel = wbm.sel[4*k +: 4];
                own_cti = wbm.cti[3*k +: 3];
                own_bte = wbm.bte[2*k +: 2];
            end
        end
    end

    // Round-robin search. The scan starts just after the last winner and
    // wraps around. It therefore reaches the last winner itself only at
    // the end, which gives that master the lowest priority.
    always_comb begin
        req_found = 1'b0;
        win_idx   = last_q;
        cand      = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = (int'(last_q) + i) % NUM_MASTERS;
            if (!req_found && wbm.cyc[cand]) begin
                req_found = 1'b1;
                win_idx   = IDXW'(cand);
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       stalled;

    // The watchdog counts cycles in which the owner is strobing and no
    // response arrives. It fires on the cycle in which the count reaches
    // TIMEOUT_CYCLES-1. A response on that same cycle prevents it from
    // firing.
    always_comb begin
        stalled   = is_own && own_cyc && own_stb && !slv_resp;
        timeout   = stalled && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d = 8'd0;
        if (stalled && !timeout) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    // Without the watchdog, a slave that never responds stalls the bus.
    logic [7:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 8'(TIMEOUT_CYCLES);
    assign timeout            = 1'b0;
`endif

    // Slave-side outputs. These are a combinational pass-through of the
    // owner's lane. cyc and stb fall on the same cycle in which the owner
    // drops cyc or the watchdog aborts.
    always_comb begin
        wbs.cyc   = is_own & own_cyc & ~timeout;
        wbs.stb   = is_own & own_cyc & own_stb & ~timeout;
        wbs.we    = is_own & own_we;
        wbs.adr   = own_adr;
        wbs.dat_w = own_dat;
        wbs.sel   = own_sel;
        wbs.cti   = own_cti;
        wbs.bte   = own_bte;
    end

    // Master-side responses. Read data is broadcast, but handshakes are
    // routed only to the current owner.
    always_comb begin
        wbm.dat_r = wbs.dat_r;
        wbm.ack   = '0;
        wbm.err   = '0;
        wbm.rty   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            wbm.ack[k] = is_own & grant_q[k] & wbs.ack[0];
            wbm.err[k] = is_own & grant_q[k] & (wbs.err[0] | timeout);
            wbm.rty[k] = is_own & grant_q[k] & wbs.rty[0];
        end
    end

    // Next-state logic: grant in IDLE, release when the owner leaves or
    // the cycle is aborted.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    state_d          = ST_OWN;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
                end
            end
            ST_OWN: begin
                if (!own_cyc || timeout) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Arbiter state registers. After reset the pointer is the highest
    // index, so master 0 wins first.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDXW'(NUM_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_io_arbiter.sv
// ============================================================================
//  Module      : tb_wb_io_arbiter
//  Description : Directed self-checking bench for wb_io_arbiter with two
//                masters. The expected values are hand-derived constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_io_arbiter;

    localparam int NM = 2;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 255;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [NM-1:0] grant;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_io_arbiter_if #(.N(NM)) m_bus ();
    wb_io_arbiter_if #(.N(1))  s_bus ();

    wb_io_arbiter #(
        .NUM_MASTERS    (NM),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm        (m_bus),
        .wbs        (s_bus),
        .grant_o    (grant)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        m_bus.cyc[k]            = cyc;
        m_bus.stb[k]            = stb;
        m_bus.we[k]             = 1'b0;
        m_bus.adr[32*k +: 32]   = adr;
        m_bus.dat_w[32*k +: 32] = 32'h0;
        m_bus.sel[4*k +: 4]     = 4'hF;
        m_bus.cti[3*k +: 3]     = cti;
        m_bus.bte[2*k +: 2]     = 2'b00;
    endtask

    task automatic slave(input logic ack, input logic err, input logic [31:0] dat);
        s_bus.ack[0] = ack;
        s_bus.err[0] = err;
        s_bus.rty[0] = 1'b0;
        s_bus.dat_r  = dat;
    endtask

    task automatic do_reset();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        slave(1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        slave(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        check("rst_grant", grant, 32'h0);
        check("rst_cyc", s_bus.cyc, 32'h0);
        check("rst_stb", s_bus.stb, 32'h0);
        check("rst_we", s_bus.we, 32'h0);
        check("rst_ack", m_bus.ack, 32'h0);
        check("rst_err", m_bus.err, 32'h0);
        check("rst_rty", m_bus.rty, 32'h0);
        rst_n = 1'b1;

        // ---------------- single request ----------------
        tick();
        set_m(0, 1'b1, 1'b1, 32'h0000_1000, 3'b000);
        settle();
        check("t1_idle_cyc", s_bus.cyc, 32'h0);
        tick();
        check("t1_grant", grant, 32'h1);
        check("t1_cyc", s_bus.cyc, 32'h1);
        check("t1_adr", s_bus.adr, 32'h0000_1000);
        tick();
        check("t1_wait_ack", m_bus.ack, 32'h0);
        tick();
        slave(1'b1, 1'b0, 32'hA5A5_0001);
        settle();
        check("t1_ack", m_bus.ack, 32'h1);
        check("t1_dat", m_bus.dat_r, 32'hA5A5_0001);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        slave(1'b0, 1'b0, 32'h0);
        settle();
        check("t1_drop_cyc", s_bus.cyc, 32'h0);
        check("t1_drop_grant", grant, 32'h1);
        tick();
        check("t1_idle_grant", grant, 32'h0);

        // ---------------- contention ----------------
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h0000_1100, 3'b000);
        set_m(1, 1'b1, 1'b1, 32'h0000_1200, 3'b000);
        settle();
        check("t2_start_grant", grant, 32'h0);
        for (int r = 0; r < 4; r++) begin
            int e;
            e = r % 2;
            tick();
            check("t2_grant", grant, 32'(1) << e);
            check("t2_adr", s_bus.adr, (e == 1) ? 32'h0000_1200 : 32'h0000_1100);
            slave(1'b1, 1'b0, 32'hC0DE_0000 + 32'(r));
            settle();
            check("t2_ack", m_bus.ack, 32'(1) << e);
            tick();
            set_m(e, 1'b0, 1'b0, 32'h0, 3'b000);
            slave(1'b0, 1'b0, 32'h0);
            settle();
            check("t2_drop_cyc", s_bus.cyc, 32'h0);
            check("t2_drop_ack", m_bus.ack, 32'h0);
            tick();
            check("t2_idle_grant", grant, 32'h0);
            set_m(e, 1'b1, 1'b1, (e == 1) ? 32'h0000_1200 : 32'h0000_1100, 3'b000);
        end

        // ---------------- hold during burst ----------------
        do_reset();
        set_m(1, 1'b1, 1'b1, 32'h0000_2000, 3'b010);
        tick();
        check("t3_grant_m1", grant, 32'h2);
        set_m(0, 1'b1, 1'b1, 32'h0000_3000, 3'b000);
        for (int b = 0; b < 4; b++) begin
            set_m(1, 1'b1, 1'b1, 32'h0000_2000 + 32'(4 * b), (b == 3) ? 3'b111 : 3'b010);
            slave(1'b1, 1'b0, 32'h0000_00B0 + 32'(b));
            settle();
            check("t3_adr", s_bus.adr, 32'h0000_2000 + 32'(4 * b));
            check("t3_cti", s_bus.cti, (b == 3) ? 32'h7 : 32'h2);
            check("t3_ack", m_bus.ack, 32'h2);
            check("t3_hold_grant", grant, 32'h2);
            tick();
        end
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        slave(1'b0, 1'b0, 32'h0);
        settle();
        check("t3_drop_cyc", s_bus.cyc, 32'h0);
        check("t3_drop_ack", m_bus.ack, 32'h0);
        tick();
        check("t3_idle_grant", grant, 32'h0);
        tick();
        check("t3_m0_grant", grant, 32'h1);
        check("t3_m0_adr", s_bus.adr, 32'h0000_3000);

        // ---------------- asynchronous reset mid-transfer ----------------
        check("t4_pre_cyc", s_bus.cyc, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_cyc", s_bus.cyc, 32'h0);
        check("t4_rst_stb", s_bus.stb, 32'h0);
        check("t4_rst_grant", grant, 32'h0);
        set_m(1, 1'b1, 1'b1, 32'h0000_4000, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t4_first_grant", grant, 32'h1);
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // ---------------- watchdog abort ----------------
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h0000_1800, 3'b000);
        tick();
        for (int k = 1; k < 16; k++) begin
            check("t5_wait_err", m_bus.err, 32'h0);
            check("t5_wait_cyc", s_bus.cyc, 32'h1);
            tick();
        end
        check("t5_abort_err", m_bus.err, 32'h1);
        check("t5_abort_cyc", s_bus.cyc, 32'h0);
        check("t5_abort_stb", s_bus.stb, 32'h0);
        tick();
        check("t5_idle_grant", grant, 32'h0);
        check("t5_idle_err", m_bus.err, 32'h0);
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();

        // ---------------- response on the abort cycle wins ----------------
        set_m(0, 1'b1, 1'b1, 32'h0000_1800, 3'b000);
        tick();
        check("t6_grant", grant, 32'h1);
        for (int k = 1; k < 16; k++) begin
            tick();
        end
        slave(1'b1, 1'b0, 32'h1234_5678);
        settle();
        check("t6_ack", m_bus.ack, 32'h1);
        check("t6_err", m_bus.err, 32'h0);
        check("t6_cyc", s_bus.cyc, 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        slave(1'b0, 1'b0, 32'h0);
        tick();
`else
        // ---------------- no watchdog: the bus waits indefinitely ----------------
        do_reset();
        set_m(0, 1'b1, 1'b1, 32'h0000_1800, 3'b000);
        tick();
        for (int k = 1; k <= 20; k++) begin
            check("t5_hang_err", m_bus.err, 32'h0);
            tick();
        end
        check("t5_hang_cyc", s_bus.cyc, 32'h1);
        check("t5_hang_grant", grant, 32'h1);
        set_m(0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_io_arbiter.md
Name: wb_io_arbiter

Overview:
- Round-robin arbiter sharing the single Wishbone IO master port of the SoC interconnect (the 8-slave IO mux: ROM, sys, SPI flash, SPI accel, PTC, GPIO, GPIO buttons, UART) between NUM_MASTERS requesters, e.g. the core LSU bridge and a debug/DMA master.
- Grants the bus to one master per Wishbone cycle and holds it until that master drops cyc.
- Drives the interconnect IO port; per-master responses are gated to the owner only.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, 2..8.
- TIMEOUT_CYCLES, 255: cycles the owner's stb may wait without ack/err/rty before abort; 8-bit counter range, >=2.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- wbm_adr_i  in  32*NUM_MASTERS  master addresses; master k at bits [32k+31:32k]. Same packing for all wbm_* buses.
- wbm_dat_i  in  32*NUM_MASTERS  master write data.
- wbm_sel_i  in  4*NUM_MASTERS  byte selects.
- wbm_we_i  in  NUM_MASTERS  write enables.
- wbm_cyc_i  in  NUM_MASTERS  cycle requests.
- wbm_stb_i  in  NUM_MASTERS  strobes.
- wbm_cti_i  in  3*NUM_MASTERS  cycle type.
- wbm_bte_i  in  2*NUM_MASTERS  burst type.
- wbm_dat_o  out  32  read data, broadcast to all masters.
- wbm_ack_o  out  NUM_MASTERS  per-master ack.
- wbm_err_o  out  NUM_MASTERS  per-master err.
- wbm_rty_o  out  NUM_MASTERS  per-master rty.
- wbs_adr_o  out  32  to interconnect io port; same for dat/sel/we/cyc/stb/cti/bte.
- wbs_dat_o  out  32; wbs_sel_o out 4; wbs_we_o out 1; wbs_cyc_o out 1; wbs_stb_o out 1; wbs_cti_o out 3; wbs_bte_o out 2.
- wbs_dat_i  in  32  read data from interconnect.
- wbs_ack_i  in  1; wbs_err_i  in  1; wbs_rty_i  in  1: interconnect responses.
- grant_o  out  NUM_MASTERS  one-hot current owner, 0 when idle (debug/status).

Behaviour:
- Reset (wb_rst_n_i low, async): state IDLE, grant_o=0, last-grant pointer = NUM_MASTERS-1 (master 0 wins first). wbs_cyc_o, wbs_stb_o, wbs_we_o and all wbm_ack/err/rty_o = 0. Timeout counter = 0.
- IDLE: wbs_cyc_o=wbs_stb_o=0. If any wbm_cyc_i is set, the winner is the first requester scanning from last-grant+1 upward with wrap-around. Registered: grant_o one-hot next cycle, state OWN, pointer := winner. Arbitration latency is 1 cycle from cyc to slave-side cyc.
- OWN: wbs_* outputs combinationally muxed from the owner's wbm_* inputs. Owner's ack/err/rty = wbs_*_i; all other masters' ack/err/rty = 0. wbm_dat_o = wbs_dat_i always.
- Ownership holds across multiple stb beats and bursts for as long as owner cyc stays high; other requests wait.
- Owner drops cyc: same cycle wbs_cyc_o=0 (combinational); next state IDLE, grant_o=0. Re-arbitration happens in IDLE, so there is at least 1 idle cycle between owners.
- Simultaneous requests: strict rotation. With masters 0 and 1 both requesting continuously, the grant sequence is 0,1,0,1.
- A master that drops cyc while not owner loses nothing; no request is queued.
- Reset mid-transfer: outputs clear immediately; slaves must tolerate the aborted cycle.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined: 8-bit counter increments each OWN cycle with owner stb=1 and ack|err|rty=0; it clears on any response or in IDLE. When count reaches TIMEOUT_CYCLES-1 with still no response, for one cycle: owner wbm_err_o=1 and wbs_cyc_o=wbs_stb_o=0 (forced abort). Then state IDLE, counter 0. A slave response arriving on that same cycle wins: it is forwarded and no err is generated.
- Not defined: no counter, and the bus hangs indefinitely on a non-responding slave.

Test Plan:
- Reset then single request: m0 cyc/stb read at 0x00001000, slave acks after 2 cycles -> wbs_cyc_o rises 1 cycle after request; m0 gets ack and dat 0xA5A5_0001; m1 ack=0; grant_o=01.
- Contention: m0 and m1 assert cyc on the same cycle, each doing 1-beat transfers repeatedly -> grant_o sequence 01,00,10,00,01; each master gets exactly one ack per ownership.
- Hold: m1 owns and does a 4-beat burst to 0x00002000 (cti=010, then 111) while m0 requests -> m0 sees no ack until m1 drops cyc; m0 is granted 2 cycles later.
- Mid-transfer reset: m0 owns with stb high; pull wb_rst_n_i low asynchronously -> wbs_cyc_o and grant_o fall without a clock edge; after release, m0 is granted first.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: m0 accesses 0x00001800 with no slave ack -> m0 err pulses exactly 1 cycle on the 16th waiting cycle; wbs_cyc_o=0 that cycle; bus then IDLE.
- WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16: slave ack on the 16th waiting cycle -> ack forwarded, err stays 0.
